add8_rr_sched: RTL and testbench

- Time-shares one external combinational 8-bit adder (sum only; no carry in or carry out) among NREQ requesters.
- Each request is an (8*NBYTES)-bit unsigned add. The block runs it byte-serially through the adder and returns the sum plus carry-out.
- Because the adder has no carry-in, the block applies an inter-byte carry with a second adder pass that adds 1.
- Sits between requester agents and the shared adder instance.

---
 rtl/add8_rr_sched.sv | 154 +++++++++++++++
 tb/tb_add8_rr_sched.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/add8_rr_sched.sv
// Byte-serial W-bit adder that time-shares one external 8-bit adder among NREQ round-robin requesters.
// Optional macro ADD8_RR_SCHED_SAT_EN: saturate rsp_sum to all-ones when the final carry-out is set.
module add8_rr_sched #(
    parameter int NREQ   = 4,
    parameter int NBYTES = 4,
    parameter int IDW    = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NREQ-1:0]        req_valid,
    output logic [NREQ-1:0]        req_ready,
    input  logic [NREQ*8*NBYTES-1:0] req_a,
    input  logic [NREQ*8*NBYTES-1:0] req_b,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [8*NBYTES-1:0]    rsp_sum,
    output logic                   rsp_cout,
    output logic [7:0]             add_a,
    output logic [7:0]             add_b,
    input  logic [7:0]             add_s
);
    localparam int W  = 8 * NBYTES;
    localparam int KW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

    typedef enum logic [1:0] {IDLE, ADD, INC, RESP} state_t;

    state_t         state, state_nxt;
    logic [W-1:0]   a_reg, b_reg, sum_reg;
    logic [IDW-1:0] id_reg, ptr, gnt_id;
    logic           gnt_vld;
    logic [KW-1:0]  k;
    logic           cf, c1_reg, cout_reg;
    logic [7:0]     t_reg, byte_a, byte_b;
    logic           c1, cf_inc, last, accept;

    assign byte_a = a_reg[8*k +: 8];
    assign byte_b = b_reg[8*k +: 8];
    // Carry out of the byte add reconstructed from operand MSBs and the sum MSB.
    assign c1     = (byte_a[7] & byte_b[7]) | ((byte_a[7] ^ byte_b[7]) & ~add_s[7]);
    assign cf_inc = c1_reg | (t_reg == 8'hFF);
    assign last   = (k == KW'(NBYTES - 1));
    assign accept = (state == IDLE) && gnt_vld;

    // Round-robin scan starting at ptr, wrapping at NREQ.
    always_comb begin : arb
        int             j;
        logic [IDW-1:0] scan_id;
        gnt_vld = 1'b0;
        gnt_id  = '0;
        j       = 0;
        scan_id = '0;
        for (int i = 0; i < NREQ; i++) begin
            j = int'(ptr) + i;
            if (j >= NREQ) j = j - NREQ;
            scan_id = IDW'(j);
            if (!gnt_vld && req_valid[scan_id]) begin
                gnt_vld = 1'b1;
                gnt_id  = scan_id;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (gnt_vld) state_nxt = ADD;
            ADD: begin
                if (cf)        state_nxt = INC;
                else if (last) state_nxt = RESP;
                else           state_nxt = ADD;
            end
            INC:  state_nxt = last ? RESP : ADD;
            RESP: if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        add_a     = 8'h00;
        add_b     = 8'h00;
        req_ready = '0;
        rsp_valid = 1'b0;
        case (state)
            IDLE: if (gnt_vld) req_ready[gnt_id] = 1'b1;
            ADD: begin
                add_a = byte_a;
                add_b = byte_b;
            end
            INC: begin
                add_a = t_reg;
                add_b = 8'h01;
            end
            RESP: rsp_valid = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            id_reg   <= '0;
            ptr      <= '0;
            k        <= '0;
            cf       <= 1'b0;
            c1_reg   <= 1'b0;
            cout_reg <= 1'b0;
            t_reg    <= 8'h00;
        end else begin
            if (accept) begin
                a_reg  <= req_a[gnt_id*W +: W];
                b_reg  <= req_b[gnt_id*W +: W];
                id_reg <= gnt_id;
                k      <= '0;
                cf     <= 1'b0;
                ptr    <= (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + 1'b1;
            end
            if (state == ADD) begin
                if (cf) begin
                    // Pending carry: hold the raw byte sum for the +1 pass.
                    t_reg  <= add_s;
                    c1_reg <= c1;
                end else begin
                    sum_reg[8*k +: 8] <= add_s;
                    cf                <= c1;
                    if (last) cout_reg <= c1;
                    else      k        <= k + 1'b1;
                end
            end
            if (state == INC) begin
                sum_reg[8*k +: 8] <= add_s;
                cf                <= cf_inc;
                if (last) cout_reg <= cf_inc;
                else      k        <= k + 1'b1;
            end
        end
    end

    assign rsp_id   = id_reg;
    assign rsp_cout = cout_reg;
`ifdef ADD8_RR_SCHED_SAT_EN
    assign rsp_sum  = cout_reg ? {W{1'b1}} : sum_reg;
`else
    assign rsp_sum  = sum_reg;
`endif

endmodule

// File: tb/tb_add8_rr_sched.sv
// Directed bench for add8_rr_sched (NREQ=4, NBYTES=4) with a behavioural 8-bit adder.
module tb_add8_rr_sched;
    logic         clk;
    logic         rst_n;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a, req_b;
    logic         rsp_valid, rsp_ready;
    logic [1:0]   rsp_id;
    logic [31:0]  rsp_sum;
    logic         rsp_cout;
    logic [7:0]   add_a, add_b, add_s;

    int n_tests = 0;
    int n_fail  = 0;
    int multi_hot = 0;

`ifdef ADD8_RR_SCHED_SAT_EN
    localparam logic [31:0] OVF_SUM = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] OVF_SUM = 32'h0000_0000;
`endif

    add8_rr_sched #(.NREQ(4), .NBYTES(4), .IDW(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_cout(rsp_cout),
        .add_a(add_a), .add_b(add_b), .add_s(add_s)
    );

    assign add_s = add_a + add_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (rst_n && !$onehot0(req_ready)) multi_hot++;

    // Present one request at a negedge, let it be accepted, wait for the response and handshake it.
    task automatic drive_req(input int id, input logic [31:0] a, input logic [31:0] b,
                             output logic [3:0] rdy, output int lat, output logic [31:0] sum,
                             output logic [1:0] rid, output logic cout);
        req_a[id*32 +: 32] = a;
        req_b[id*32 +: 32] = b;
        req_valid[id] = 1'b1;
        #1 rdy = req_ready;
        @(posedge clk);
        @(negedge clk);
        req_valid[id] = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        if (!rsp_valid) lat = -1;
        sum  = rsp_sum;
        rid  = rsp_id;
        cout = rsp_cout;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++;
        if ({rsp_valid, req_ready, rsp_id, rsp_sum, rsp_cout, add_a, add_b} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got v=%b rdy=%b id=%0d sum=%h c=%b a=%h b=%h want all zero",
                     rsp_valid, req_ready, rsp_id, rsp_sum, rsp_cout, add_a, add_b);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_vectors();
        logic [3:0] rdy; int lat; logic [31:0] sum; logic [1:0] rid; logic cout;
        logic [31:0] va [4] = '{32'h0000_0012, 32'hFFFF_FFFF, 32'h00FF_FF80, 32'h8000_0000};
        logic [31:0] vb [4] = '{32'h0000_0034, 32'h0000_0001, 32'h0000_0080, 32'h8000_0000};
        logic [31:0] es [4] = '{32'h0000_0046, OVF_SUM,      32'h0100_0000, OVF_SUM};
        logic        ec [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        int          el [4] = '{4, 7, 7, 4};
        for (int i = 0; i < 4; i++) begin
            drive_req(i, va[i], vb[i], rdy, lat, sum, rid, cout);
            n_tests++;
            if (rdy !== (4'b0001 << i)) begin
                n_fail++; $display("FAIL vec%0d_ready: got %b want %b", i, rdy, 4'b0001 << i);
            end
            n_tests++;
            if (lat !== el[i]) begin
                n_fail++; $display("FAIL vec%0d_latency: got %0d want %0d", i, lat, el[i]);
            end
            n_tests++;
            if (rid !== 2'(i)) begin
                n_fail++; $display("FAIL vec%0d_id: got %0d want %0d", i, rid, i);
            end
            n_tests++;
            if (sum !== es[i]) begin
                n_fail++; $display("FAIL vec%0d_sum: got %h want %h", i, sum, es[i]);
            end
            n_tests++;
            if (cout !== ec[i]) begin
                n_fail++; $display("FAIL vec%0d_cout: got %b want %b", i, cout, ec[i]);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [31:0] ra [4] = '{32'h1111_1111, 32'h0102_0304, 32'h0000_00FF, 32'h7FFF_FFFF};
        logic [31:0] rb [4] = '{32'h2222_2222, 32'h1020_3040, 32'h0000_0001, 32'h0000_0001};
        logic [31:0] rs [4] = '{32'h3333_3333, 32'h1122_3344, 32'h0000_0100, 32'h8000_0000};
        int          rl [4] = '{4, 4, 5, 7};
        int t, lat, w;
        for (int i = 0; i < 4; i++) begin
            req_a[i*32 +: 32] = ra[i];
            req_b[i*32 +: 32] = rb[i];
        end
        req_valid = 4'hF;
        #1;
        for (int g = 0; g < 5; g++) begin
            w = g % 4;
            t = 0;
            while (req_ready == '0 && t < 20) begin
                @(negedge clk);
                t++;
            end
            n_tests++;
            if (req_ready !== (4'b0001 << w)) begin
                n_fail++; $display("FAIL rr_grant%0d: got %b want %b", g, req_ready, 4'b0001 << w);
            end
            @(posedge clk);
            @(negedge clk);
            if (g == 4) req_valid = '0;
            lat = 0;
            while (!rsp_valid && lat < 50) begin
                @(negedge clk);
                lat++;
            end
            n_tests++;
            if (!rsp_valid || lat !== rl[w] || rsp_id !== 2'(w) || rsp_sum !== rs[w] || rsp_cout !== 1'b0) begin
                n_fail++;
                $display("FAIL rr_rsp%0d: got v=%b lat=%0d id=%0d sum=%h c=%b want lat=%0d id=%0d sum=%h c=0",
                         g, rsp_valid, lat, rsp_id, rsp_sum, rsp_cout, rl[w], w, rs[w]);
            end
        end
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (multi_hot !== 0) begin
            n_fail++; $display("FAIL rr_onehot: got %0d multi-hot cycles want 0", multi_hot);
        end
    endtask

    task automatic test_backpressure();
        int lat, bad;
        req_a[32 +: 32] = 32'h0000_0005; req_b[32 +: 32] = 32'h0000_0006;
        req_valid = 4'b0010;
        #1;
        n_tests++;
        if (req_ready !== 4'b0010) begin
            n_fail++; $display("FAIL bp_grant: got %b want %b", req_ready, 4'b0010);
        end
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        req_a[96 +: 32] = 32'h0000_0001; req_b[96 +: 32] = 32'h0000_0002;
        req_valid = 4'b1000;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (!rsp_valid || rsp_sum !== 32'h0000_000B || rsp_id !== 2'd1 || req_ready !== 4'b0000) begin
                bad++;
                $display("FAIL bp_hold_cycle%0d: got v=%b sum=%h id=%0d rdy=%b want v=1 sum=0000000b id=1 rdy=0000",
                         c, rsp_valid, rsp_sum, rsp_id, req_ready);
            end
            @(negedge clk);
        end
        n_tests++;
        if (bad !== 0) n_fail++;
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b1000) begin
            n_fail++; $display("FAIL bp_resume: got v=%b rdy=%b want v=0 rdy=1000", rsp_valid, req_ready);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        n_tests++;
        if (rsp_sum !== 32'h0000_0003 || rsp_id !== 2'd3 || lat !== 4) begin
            n_fail++; $display("FAIL bp_next_rsp: got sum=%h id=%0d lat=%0d want 00000003 id=3 lat=4",
                               rsp_sum, rsp_id, lat);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset_mid_add();
        int lat;
        req_a[64 +: 32] = 32'h0101_0101; req_b[64 +: 32] = 32'h0101_0101;
        req_valid = 4'b0100;
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (add_a !== 8'h01 || add_b !== 8'h01) begin
            n_fail++; $display("FAIL rst_pre_add: got a=%h b=%h want 01 01", add_a, add_b);
        end
        rst_n = 1'b0;
        #1;
        n_tests++;
        if ({rsp_valid, req_ready, rsp_id, rsp_sum, rsp_cout, add_a, add_b} !== '0) begin
            n_fail++;
            $display("FAIL rst_async: got v=%b rdy=%b id=%0d sum=%h c=%b a=%h b=%h want all zero",
                     rsp_valid, req_ready, rsp_id, rsp_sum, rsp_cout, add_a, add_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        n_tests++;
        if (rsp_valid !== 1'b0) begin
            n_fail++; $display("FAIL rst_no_rsp: got rsp_valid=%b want 0", rsp_valid);
        end
        // Pointer back at 0 means requester 1 beats requester 3.
        req_a[32 +: 32] = 32'h0000_0001; req_b[32 +: 32] = 32'h0000_00FF;
        req_a[96 +: 32] = 32'h0000_0009; req_b[96 +: 32] = 32'h0000_0009;
        req_valid = 4'b1010;
        #1;
        n_tests++;
        if (req_ready !== 4'b0010) begin
            n_fail++; $display("FAIL rst_ptr: got %b want %b", req_ready, 4'b0010);
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = '0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        n_tests++;
        if (rsp_sum !== 32'h0000_0100 || rsp_id !== 2'd1 || rsp_cout !== 1'b0 || lat !== 5) begin
            n_fail++; $display("FAIL rst_after: got sum=%h id=%0d c=%b lat=%0d want 00000100 id=1 c=0 lat=5",
                               rsp_sum, rsp_id, rsp_cout, lat);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_round_robin();
        test_backpressure();
        test_reset_mid_add();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end
endmodule
